display_spi_tx: RTL and testbench
=================================

# display_spi_tx

Frame transmitter for the 128x64 SSD1306 OLED. It reads the 1024-byte image produced by the image controller one byte at a time and streams it over a write-only SPI link (mode 0) with the data/command line. Each frame is preceded by a fixed addressing command header, and optionally by a one-time panel init sequence. It sits between the image controller and the top-level display pins.

## Interface
- CLK_DIV, 4: number of clk cycles in each SCLK half-period; must be at least 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send one frame; honoured only while busy=0.
- pix_addr  out  10  index of the next image byte to load; page-major order (page = addr/128, column = addr%128, bit0 = top pixel).
- pix_data  in  8  image byte at pix_addr; must be valid within 1 clk of a pix_addr change (registered source allowed).
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle pulse when the frame completes.
- sclk, mosi, cs_n, dc  out  1 each  SPI pins: clock, data MSB-first, chip select (active low), and data/command (0 = command, 1 = data).

## Operation
- States are IDLE, INIT, CMD, DATA and FINISH.
- IDLE → INIT on start when the init sequence is pending (see Configuration); otherwise IDLE → CMD.
- INIT: sends the 25 init bytes with dc=0, then moves to CMD.
- CMD: sends 0x21 0x00 0x7F 0x22 0x00 0x07 with dc=0, then moves to DATA.
- DATA: sends bytes 0..1023 in order with dc=1. pix_data for byte k is sampled at its load edge. pix_addr holds k for at least 2 cycles before that edge.
- After the last bit of byte 1023 the block enters FINISH for one cycle, then returns to IDLE.
- Bytes are contiguous: there are no SCLK gaps between bytes or between segments.
- dc changes only at byte boundaries, while sclk is low.
- cs_n stays low continuously from the first bit of the first byte to the end of the last bit.
- start while busy=1, including the cycle where done=1, is ignored and has no side effects.
- rst_n low at any time, including mid-byte, forces all outputs to their reset values immediately and re-arms the init sequence.
- Reset values: sclk=0, mosi=0, cs_n=1, dc=0, busy=0, done=0, pix_addr=0.
- pix_addr returns to 0 at FINISH.

## Timing
- start is sampled in cycle N. At N+1: busy=1, cs_n=0, dc and the first MSB are driven on mosi, and sclk=0.
- Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
- mosi changes only on the sclk falling transition (or at cs_n fall for the first bit). It is stable across the rising edge.
- After the final high phase: sclk=0, cs_n=1, mosi=0 and done=1 in the same cycle. busy=0 the next cycle.
- cs_n is low for exactly B·16·CLK_DIV cycles, where B = 1030 normally and B = 1055 when the init bytes are included.
- A new start is accepted no earlier than the cycle after done.

## Configuration
- SSD1306_INIT_EN defined: the first accepted start after reset sends these 25 bytes in INIT, before CMD: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF. Later frames skip INIT until the next reset.
- SSD1306_INIT_EN undefined: the INIT state and ROM are absent, and every frame is CMD+DATA (B = 1030).

## Structure
- Shared package display_pkg holds:
  - the state enum;
  - the 6-byte header constants;
  - the 25-entry init ROM constant;
  - FRAME_BYTES=1024 and HDR_BYTES=6.
- One sub-module, spi_byte_tx, contains the CLK_DIV divider, the 8-bit shifter and the bit counter. It has a load/byte-in/dc-in interface and a last-bit strobe. The top-level FSM sequences bytes and drives pix_addr.

## Test plan
- Reset: hold rst_n=0 → sclk=0, mosi=0, cs_n=1, dc=0, busy=0, done=0, pix_addr=0. Pulsing start during reset has no effect.
- Full frame, CLK_DIV=2, macro undefined, pix_data = pix_addr[7:0] via a registered model:
  - bytes decoded on sclk rising edges = 21 00 7F 22 00 07 (dc=0), then 00 01 … FF repeated 4 times (dc=1);
  - cs_n low for 32960 cycles; one done pulse.
- With SSD1306_INIT_EN, two back-to-back frames:
  - frame 1 starts AE D5 80 … AF, then 21 00 7F …;
  - frame 2 starts directly with 21;
  - after a reset, a third frame starts with AE again.
- start pulsed mid-frame and in the done cycle → ignored: byte stream unchanged, single done. start the cycle after done → accepted.
- rst_n asserted during byte 500 → outputs reach reset values in the same cycle. The next start produces a complete, correct frame from byte 0.
- CLK_DIV=1 → sclk toggles every cycle, mosi is stable at each rising edge, and frame length = 16480 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the SSD1306 frame transmitter.
//   - state_t     : frame sequencer states
//   - HDR_ROM     : 6-byte column/page addressing header sent before every frame
//   - INIT_ROM    : 25-byte panel init sequence (only with SSD1306_INIT_EN)
//   - FRAME_BYTES : image size in bytes (128 columns x 8 pages)
//   - HDR_BYTES   : header length in bytes
// Optional feature macro: SSD1306_INIT_EN (adds the INIT state and ROM).
package display_pkg;

  localparam int unsigned FRAME_BYTES = 1024;
  localparam int unsigned HDR_BYTES   = 6;

`ifdef SSD1306_INIT_EN
  localparam int unsigned INIT_BYTES = 25;

  typedef enum logic [2:0] {IDLE, INIT, CMD, DATA, FINISH} state_t;

  localparam logic [7:0] INIT_ROM [INIT_BYTES] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    return (idx < 5'(INIT_BYTES)) ? INIT_ROM[idx] : 8'h00;
  endfunction
`else
  typedef enum logic [2:0] {IDLE, CMD, DATA, FINISH} state_t;
`endif

  // Full column range 0..127, full page range 0..7.
  localparam logic [7:0] HDR_ROM [HDR_BYTES] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    return (idx < 3'(HDR_BYTES)) ? HDR_ROM[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/display_spi_tx_byte.sv
// spi_byte_tx: SPI mode-0 byte serialiser with SCLK divider.
// Ports:
//   clk, rst_n       : system clock, async active-low reset
//   load             : load byte_in/dc_in and start shifting (legal when idle
//                      or in the same cycle last_bit is high)
//   byte_in, dc_in   : byte to send MSB-first and its data/command flag
//   sclk, mosi, dc   : SPI clock, serial data, data/command line
//   last_bit         : high in the final cycle of bit 7's high phase
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       dc_in,
  output logic       sclk,
  output logic       mosi,
  output logic       dc,
  output logic       last_bit
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic          active;
  logic          sclk_q;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          dc_q;

  assign sclk     = sclk_q;
  assign mosi     = shreg[7];
  assign dc       = dc_q;
  assign last_bit = active && sclk_q && (bit_cnt == 3'd7) && (div_cnt == DIV_MAX);

  // A load in the last_bit cycle restarts the low phase directly, so
  // consecutive bytes have no gap in SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      dc_q    <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= byte_in;
      dc_q    <= dc_in;
    end else if (active) begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        sclk_q  <= ~sclk_q;
        if (sclk_q) begin
          // falling transition: advance to next bit or stop
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            shreg  <= '0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/display_spi_tx.sv
// display_spi_tx: SSD1306 frame transmitter. Sends an addressing header and
// the 1024-byte image (page-major) over SPI mode 0 for each accepted start.
// Ports:
//   clk, rst_n              : system clock, async active-low reset
//   start                   : one-cycle frame request, honoured while busy=0
//   pix_addr / pix_data     : image byte read port (1-cycle latency allowed)
//   busy, done              : frame in progress / one-cycle completion pulse
//   sclk, mosi, cs_n, dc    : SPI pins
// Parameter CLK_DIV: clk cycles per SCLK half-period (>= 1).
// Optional macro SSD1306_INIT_EN: first frame after reset is preceded by the
// 25-byte panel init sequence.
module display_spi_tx
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [9:0] pix_addr,
  input  logic [7:0] pix_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       dc
);

  state_t     state, state_nxt;
  logic [9:0] idx, nidx;
  logic       last_bit;
  logic       load;
  logic [7:0] load_byte;
  logic       load_dc;

`ifdef SSD1306_INIT_EN
  logic init_pending;
`endif

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .byte_in  (load_byte),
    .dc_in    (load_dc),
    .sclk     (sclk),
    .mosi     (mosi),
    .dc       (dc),
    .last_bit (last_bit)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SSD1306_INIT_EN
          state_nxt = init_pending ? INIT : CMD;
`else
          state_nxt = CMD;
`endif
        end
      end
`ifdef SSD1306_INIT_EN
      INIT:   if (last_bit && idx == 10'(INIT_BYTES - 1)) state_nxt = CMD;
`endif
      CMD:    if (last_bit && idx == 10'(HDR_BYTES - 1))   state_nxt = DATA;
      DATA:   if (last_bit && idx == 10'(FRAME_BYTES - 1)) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs and byte selection; the next byte is chosen from the state it
  // belongs to, so segment changes and in-segment steps share one path
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FINISH);
    cs_n      = (state == IDLE) || (state == FINISH);
    load      = (state == IDLE && start) || (last_bit && state_nxt != FINISH);
    nidx      = (state_nxt != state) ? '0 : idx + 10'd1;
    load_byte = '0;
    load_dc   = 1'b0;
    case (state_nxt)
`ifdef SSD1306_INIT_EN
      INIT: load_byte = init_byte(nidx[4:0]);
`endif
      CMD:  load_byte = hdr_byte(nidx[2:0]);
      DATA: begin
        load_byte = pix_data;
        load_dc   = 1'b1;
      end
      default: load_byte = '0;
    endcase
  end

  // byte index and image address; pix_addr moves to k+1 when byte k is
  // loaded, giving the source a full byte time before the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      pix_addr <= '0;
    end else begin
      if (load) idx <= nidx;
      if (state == FINISH)
        pix_addr <= '0;
      else if (load && state_nxt == DATA)
        pix_addr <= pix_addr + 10'd1;
    end
  end

`ifdef SSD1306_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     init_pending <= 1'b1;
    else if (state == IDLE && start) init_pending <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_display_spi_tx.sv
module tb_display_spi_tx;

  localparam logic [7:0] HDR [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  localparam logic [7:0] INIT_SEQ [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
`ifdef SSD1306_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;  // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance

  logic       start2, start1;
  logic [9:0] pa2, pa1;
  logic [7:0] pd2, pd1;
  logic       busy2, done2, sclk2, mosi2, cs_n2, dc2;
  logic       busy1, done1, sclk1, mosi1, cs_n1, dc1;
  logic       m_busy, m_done, m_sclk, m_mosi, m_cs_n, m_dc;

  always #5 clk = ~clk;

  assign start2 = start && !sel;
  assign start1 = start && sel;

  display_spi_tx #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pix_addr(pa2), .pix_data(pd2),
    .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .dc(dc2)
  );

  display_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pix_addr(pa1), .pix_data(pd1),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .dc(dc1)
  );

  // registered image sources: byte value = low 8 bits of its address
  always_ff @(posedge clk) begin
    pd2 <= pa2[7:0];
    pd1 <= pa1[7:0];
  end

  always_comb begin
    if (sel) begin
      m_busy = busy1; m_done = done1; m_sclk = sclk1;
      m_mosi = mosi1; m_cs_n = cs_n1; m_dc = dc1;
    end else begin
      m_busy = busy2; m_done = done2; m_sclk = sclk2;
      m_mosi = mosi2; m_cs_n = cs_n2; m_dc = dc2;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push_frame(input bit with_init);
    if (with_init)
      for (int i = 0; i < 25; i++) sb.push_back({1'b0, INIT_SEQ[i]});
    for (int i = 0; i < 6; i++) sb.push_back({1'b0, HDR[i]});
    for (int k = 0; k < 1024; k++) sb.push_back({1'b1, 8'(k)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: decodes bytes at SCLK rising edges, measures cs_n low time
  int         bits = 0;
  logic [7:0] shv = '0;
  logic       cur_dc = 1'b0;
  logic       prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;
  int         cs_cnt = 0, last_cs_len = 0, done_cnt = 0, bytes_total = 0;

  always @(negedge clk) begin
    logic [8:0] want;
    if (!rst_n) begin
      bits = 0; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1; cs_cnt = 0;
    end else begin
      if (!m_cs_n) cs_cnt++;
      if (m_done) begin
        done_cnt++;
        last_cs_len = cs_cnt;
        cs_cnt = 0;
      end
      if (sel && !m_cs_n && !prev_cs) check("sclk_toggle", 32'(m_sclk), 32'(!prev_sclk));
      if (m_sclk && !prev_sclk) begin
        check("mosi_stable", 32'(m_mosi), 32'(prev_mosi));
        if (bits == 0) cur_dc = m_dc;
        shv = {shv[6:0], m_mosi};
        bits++;
        if (bits == 8) begin
          bits = 0;
          bytes_total++;
          check("dc_stable", 32'(m_dc), 32'(cur_dc));
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            want = sb.pop_front();
            check("byte", 32'({cur_dc, shv}), 32'(want));
          end
        end
      end
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
      prev_cs   = m_cs_n;
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (m_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 32'(m_done), 32'd1);
  endtask

  task automatic check_first_cycle(input bit with_init);
    check("n1_busy", 32'(m_busy), 32'd1);
    check("n1_pins", 32'({m_cs_n, m_sclk, m_dc}), 32'd0);
    check("n1_msb", 32'(m_mosi), with_init ? 32'd1 : 32'd0);
  endtask

  initial begin
    int d0, base, n;

    // reset, with start pulses that must have no effect
    repeat (2) step();
    start = 1'b1; step(); start = 1'b0; step();
    sel = 1'b1; start = 1'b1; step(); start = 1'b0; sel = 1'b0; step();
    check("rst_dut2", 32'({sclk2, mosi2, cs_n2, dc2, busy2, done2, pa2}), 32'({6'b001000, 10'd0}));
    check("rst_dut1", 32'({sclk1, mosi1, cs_n1, dc1, busy1, done1, pa1}), 32'({6'b001000, 10'd0}));
    rst_n = 1'b1;
    repeat (2) step();

    // frame 1: CLK_DIV=2, stray start mid-frame and in the done cycle
    push_frame(INIT_ON);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    check_first_cycle(INIT_ON);
    repeat (200) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(40000);
    check("done_pins", 32'({m_sclk, m_cs_n, m_mosi}), 32'b010);
    start = 1'b1; step(); start = 1'b0;
    check("busy_after_done", 32'(m_busy), 32'd0);
    step();
    check("done_start_ignored", 32'(m_busy), 32'd0);
    check("f1_done_count", 32'(done_cnt - d0), 32'd1);
    check("f1_cs_len", 32'(last_cs_len), 32'((INIT_ON ? 1055 : 1030) * 32));
    check("f1_sb_empty", 32'(sb.size()), 32'd0);

    // frame A: CLK_DIV=1, then start held from the done cycle into the next
    sel = 1'b1;
    step();
    push_frame(INIT_ON);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    check_first_cycle(INIT_ON);
    wait_done(20000);
    check("fa_sb_empty", 32'(sb.size()), 32'd0);
    push_frame(1'b0);
    start = 1'b1; step();
    check("fa_busy_after_done", 32'(m_busy), 32'd0);
    step(); start = 1'b0;
    check_first_cycle(1'b0);
    check("fa_done_count", 32'(done_cnt - d0), 32'd1);
    check("fa_cs_len", 32'(last_cs_len), 32'((INIT_ON ? 1055 : 1030) * 16));

    // frame B: reset during data byte 500
    base = bytes_total;
    n = 0;
    while (bytes_total - base < 6 + 500 && n < 20000) begin
      step();
      n++;
    end
    check("reach_byte500", 32'(bytes_total - base >= 506), 32'd1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("midrst_dut1", 32'({sclk1, mosi1, cs_n1, dc1, busy1, done1, pa1}), 32'({6'b001000, 10'd0}));
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // recovery frame: complete from byte 0, init re-armed by the reset
    push_frame(INIT_ON);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    check_first_cycle(INIT_ON);
    wait_done(20000);
    step();
    check("fr_busy_end", 32'(m_busy), 32'd0);
    check("fr_pix_addr", 32'(pa1), 32'd0);
    check("fr_done_count", 32'(done_cnt - d0), 32'd1);
    check("fr_cs_len", 32'(last_cs_len), 32'((INIT_ON ? 1055 : 1030) * 16));
    check("fr_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
